pipelined_barrel_rotator: RTL and testbench

- Parametrised N-bit shifter/rotator for a stream of data words.
- Shift amount, direction and mode (circular or logical) arrive per transaction at run time.
- One log2(N) binary stage per pipeline register, with a valid/ready handshake on both sides.
- Sits between a producer and a consumer as a throughput-1, fixed-latency datapath element that tolerates back-pressure.

---
 rtl/pipelined_barrel_rotator.sv | 90 +++++++++
 tb/tb_pipelined_barrel_rotator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_rotator.sv
// pipelined_barrel_rotator: N-bit rotate/logical shift, one log2 stage per register.
// Ports: clk, rst (sync, active-high), up_* valid/ready operand side, down_* result side.
module pipelined_barrel_rotator #(
  parameter int N = 8,
  localparam int A = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [N-1:0] up_data,
  input  logic [A-1:0] up_amt,
  input  logic         up_dir,
  input  logic         up_mode,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [N-1:0] down_data
);

  typedef struct packed {
    logic         valid;
    logic         dir;
    logic         mode;
    logic [A-1:0] amt;
    logic [N-1:0] data;
  } stg_t;

  logic [A-1:0] vld;
  logic [A-1:0] ld;

  // A stage may load if any stage at or after it is empty, or the
  // consumer takes the tail; this is the unrolled ready chain.
  always_comb begin
    logic hole;
    hole = down_ready;
    for (int k = A - 1; k >= 0; k--) begin
      hole  = hole | ~vld[k];
      ld[k] = hole;
    end
  end

  for (genvar k = 0; k < A; k++) begin : g_stg
    localparam int S = 1 << k;

    stg_t src;
    stg_t nxt;
    stg_t q;

    if (k == 0) begin : g_in
      assign src = '{valid: up_valid, dir: up_dir,
                     mode: up_mode, amt: up_amt,
                     data: up_data};
    end else begin : g_mid
      assign src = g_stg[k-1].q;
    end

    always_comb begin
      nxt = src;
      if (src.amt[k]) begin
        unique case ({src.mode, src.dir})
          2'b00:   nxt.data = (src.data << S) | (src.data >> (N - S));
          2'b01:   nxt.data = (src.data >> S) | (src.data << (N - S));
          2'b10:   nxt.data = src.data << S;
          default: nxt.data = src.data >> S;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (ld[k]) begin
        q <= nxt;
      end
    end

    assign vld[k] = q.valid;
  end

  assign up_ready   = ld[0];
  assign down_valid = g_stg[A-1].q.valid;
  assign down_data  = g_stg[A-1].q.data;

  // The tail stage's control fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{g_stg[A-1].q.dir,
                         g_stg[A-1].q.mode,
                         g_stg[A-1].q.amt};

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// tb_pipelined_barrel_rotator: scoreboard bench for the pipelined rotator.
// Drives N=8 directed/stream/back-pressure/reset cases plus N=2,16,32 streams.
module tb_pipelined_barrel_rotator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(int n, logic [31:0] a, int s,
                                         logic dir, logic mode);
    logic [31:0] m, l, r;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    a = a & m;
    s = s % n;
    if (s == 0) return a;
    l = (a << s) & m;
    r = a >> s;
    if (mode) return dir ? r : l;
    return dir ? (r | ((a << (n - s)) & m)) : (l | (a >> (n - s)));
  endfunction

  // N=8 DUT
  logic       rst, uv, ur, udir, umode, dv, dr;
  logic [7:0] ud, dd;
  logic [2:0] ua;

  pipelined_barrel_rotator #(.N(8)) u_dut (
    .clk(clk), .rst(rst),
    .up_valid(uv), .up_ready(ur), .up_data(ud),
    .up_amt(ua), .up_dir(udir), .up_mode(umode),
    .down_valid(dv), .down_ready(dr), .down_data(dd)
  );

  // width-generalisation DUTs share one stimulus bus
  logic        wrst, wv, wdir, wmode;
  logic        wdr;
  logic [31:0] wd;
  logic [4:0]  wa;
  logic        wr2, wr16, wr32, wdv2, wdv16, wdv32;
  logic [1:0]  wdd2;
  logic [15:0] wdd16;
  logic [31:0] wdd32;

  pipelined_barrel_rotator #(.N(2)) u_w2 (
    .clk(clk), .rst(wrst),
    .up_valid(wv), .up_ready(wr2), .up_data(wd[1:0]),
    .up_amt(wa[0:0]), .up_dir(wdir), .up_mode(wmode),
    .down_valid(wdv2), .down_ready(wdr), .down_data(wdd2)
  );

  pipelined_barrel_rotator #(.N(16)) u_w16 (
    .clk(clk), .rst(wrst),
    .up_valid(wv), .up_ready(wr16), .up_data(wd[15:0]),
    .up_amt(wa[3:0]), .up_dir(wdir), .up_mode(wmode),
    .down_valid(wdv16), .down_ready(wdr), .down_data(wdd16)
  );

  pipelined_barrel_rotator #(.N(32)) u_w32 (
    .clk(clk), .rst(wrst),
    .up_valid(wv), .up_ready(wr32), .up_data(wd),
    .up_amt(wa), .up_dir(wdir), .up_mode(wmode),
    .down_valid(wdv32), .down_ready(wdr), .down_data(wdd32)
  );

  // scoreboards
  logic [31:0] q8[$], q2[$], q16[$], q32[$];
  int ts8[$], ts2[$], ts16[$], ts32[$];
  int nin8 = 0, nout8 = 0, lat8 = 0, run8 = 0, maxrun8 = 0;
  int nin2 = 0, nout2 = 0, lat2 = 0;
  int nin16 = 0, nout16 = 0, lat16 = 0;
  int nin32 = 0, nout32 = 0, lat32 = 0;
  logic [7:0]  last8 = 8'h0;
  logic [31:0] last32 = 32'h0;

  always @(negedge clk) begin
    if (!rst) begin
      if (uv && ur) begin
        q8.push_back(ref_op(8, {24'b0, ud}, int'(ua), udir, umode));
        ts8.push_back(cyc);
        nin8++;
      end
      if (dv) run8++;
      else run8 = 0;
      if (run8 > maxrun8) maxrun8 = run8;
      if (dv && dr) begin
        nout8++;
        last8 = dd;
        if (q8.size() == 0) check("spurious8", 32'd1, 32'd0);
        else begin
          check("data8", {24'b0, dd}, q8.pop_front());
          lat8 = cyc - ts8.pop_front();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!wrst) begin
      if (wv && wr2) begin
        q2.push_back(ref_op(2, wd, int'(wa), wdir, wmode));
        ts2.push_back(cyc);
        nin2++;
      end
      if (wv && wr16) begin
        q16.push_back(ref_op(16, wd, int'(wa), wdir, wmode));
        ts16.push_back(cyc);
        nin16++;
      end
      if (wv && wr32) begin
        q32.push_back(ref_op(32, wd, int'(wa), wdir, wmode));
        ts32.push_back(cyc);
        nin32++;
      end
      if (wdv2 && wdr) begin
        nout2++;
        if (q2.size() == 0) check("spurious2", 32'd1, 32'd0);
        else begin
          check("data2", {30'b0, wdd2}, q2.pop_front());
          lat2 = cyc - ts2.pop_front();
        end
      end
      if (wdv16 && wdr) begin
        nout16++;
        if (q16.size() == 0) check("spurious16", 32'd1, 32'd0);
        else begin
          check("data16", {16'b0, wdd16}, q16.pop_front());
          lat16 = cyc - ts16.pop_front();
        end
      end
      if (wdv32 && wdr) begin
        nout32++;
        last32 = wdd32;
        if (q32.size() == 0) check("spurious32", 32'd1, 32'd0);
        else begin
          check("data32", wdd32, q32.pop_front());
          lat32 = cyc - ts32.pop_front();
        end
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic [2:0] a,
                       input logic dir, input logic mode);
    int t = 0;
    @(posedge clk);
    #1;
    uv = 1'b1; ud = d; ua = a; udir = dir; umode = mode;
    @(negedge clk);
    while (!ur && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ur) check("accept8", 32'd0, 32'd1);
    @(posedge clk);
    #1 uv = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q8.size() != 0) check("drain8", q8.size(), 32'd0);
  endtask

  task automatic drainw();
    int t = 0;
    while ((q2.size() + q16.size() + q32.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if ((q2.size() + q16.size() + q32.size()) != 0)
      check("drainw", q2.size() + q16.size() + q32.size(), 32'd0);
  endtask

  task automatic dir8(string tag, input logic [7:0] d, input logic [2:0] a,
                      input logic dir, input logic mode, input logic [7:0] exp);
    send8(d, a, dir, mode);
    drain8();
    check(tag, 32'(last8), 32'(exp));
    check("lat8", lat8, 32'd3);
  endtask

  int j, base_out;
  logic [7:0] hold;

  initial begin
    rst = 1'b1; uv = 1'b0; ud = '0; ua = '0; udir = 1'b0; umode = 1'b0; dr = 1'b1;
    wrst = 1'b1; wv = 1'b0; wd = '0; wa = '0; wdir = 1'b0; wmode = 1'b0; wdr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wrst = 1'b0;
    @(negedge clk);
    check("rst_dv", 32'(dv), 32'd0);
    check("rst_dd", 32'(dd), 32'd0);
    check("rst_ur", 32'(ur), 32'd1);

    dir8("rr3", 8'hB1, 3'd3, 1'b1, 1'b0, 8'h36);
    dir8("rl3", 8'hB1, 3'd3, 1'b0, 1'b0, 8'h8D);
    dir8("sr3", 8'hB1, 3'd3, 1'b1, 1'b1, 8'h16);
    dir8("sl3", 8'hB1, 3'd3, 1'b0, 1'b1, 8'h88);
    dir8("a0_rl", 8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5);
    dir8("a0_rr", 8'hA5, 3'd0, 1'b1, 1'b0, 8'hA5);
    dir8("a0_sl", 8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5);
    dir8("a0_sr", 8'hA5, 3'd0, 1'b1, 1'b1, 8'hA5);
    dir8("rl7", 8'h01, 3'd7, 1'b0, 1'b0, 8'h80);
    dir8("sr7", 8'hFF, 3'd7, 1'b1, 1'b1, 8'h01);

    // back-to-back stream
    base_out = nout8;
    maxrun8 = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      uv = 1'b1; ud = 8'($urandom); ua = 3'($urandom);
      udir = 1'($urandom); umode = 1'($urandom);
    end
    @(posedge clk);
    #1 uv = 1'b0;
    drain8();
    check("strm_cnt", nout8 - base_out, 32'd16);
    check("strm_run", maxrun8, 32'd16);

    // back-pressure: five offered, three fit
    base_out = nout8;
    j = 0;
    @(posedge clk);
    #1 dr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      uv = (j < 5); ud = 8'(j * 37 + 3); ua = 3'(j); udir = 1'(j); umode = 1'b0;
      @(negedge clk);
      if (uv && ur) j++;
      @(posedge clk);
      #1;
    end
    check("bp_acc", j, 32'd3);
    @(negedge clk);
    check("bp_ur", 32'(ur), 32'd0);
    check("bp_dv", 32'(dv), 32'd1);
    hold = dd;
    repeat (2) @(negedge clk);
    check("bp_stable", 32'(dd), 32'(hold));
    @(posedge clk);
    #1 dr = 1'b1;
    for (int c = 0; c < 30 && j < 5; c++) begin
      uv = (j < 5); ud = 8'(j * 37 + 3); ua = 3'(j); udir = 1'(j); umode = 1'b0;
      @(negedge clk);
      if (uv && ur) j++;
      @(posedge clk);
      #1;
    end
    uv = 1'b0;
    drain8();
    check("bp_out", nout8 - base_out, 32'd5);

    // random valid/ready
    for (int c = 0; c < 1000; c++) begin
      uv = 1'($urandom); ud = 8'($urandom); ua = 3'($urandom);
      udir = 1'($urandom); umode = 1'($urandom); dr = 1'($urandom);
      @(posedge clk);
      #1;
    end
    uv = 1'b0;
    dr = 1'b1;
    drain8();
    check("rnd_cnt", nout8, nin8);

    // reset with two in flight
    dr = 1'b0;
    send8(8'h3C, 3'd1, 1'b0, 1'b0);
    send8(8'hC3, 3'd2, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    ts8.delete();
    base_out = nout8;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_dv", 32'(dv), 32'd0);
    check("mrst_dd", 32'(dd), 32'd0);
    check("mrst_ur", 32'(ur), 32'd1);
    dr = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_none", nout8 - base_out, 32'd0);

    // widths 2/16/32: directed rotate right by 31 of 1
    @(posedge clk);
    #1;
    wv = 1'b1; wd = 32'h1; wa = 5'd31; wdir = 1'b1; wmode = 1'b0;
    @(posedge clk);
    #1 wv = 1'b0;
    drainw();
    check("w32_rr31", last32, 32'h2);
    check("w32_lat", lat32, 32'd5);
    check("w16_lat", lat16, 32'd4);
    check("w2_lat", lat2, 32'd1);

    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      wv = 1'b1; wd = $urandom; wa = 5'($urandom);
      wdir = 1'($urandom); wmode = 1'($urandom);
    end
    @(posedge clk);
    #1 wv = 1'b0;
    drainw();
    check("w2_cnt", nout2, 32'd65);
    check("w16_cnt", nout16, 32'd65);
    check("w32_cnt", nout32, 32'd65);
    check("w_in", nin2 + nin16 + nin32, 32'd195);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
